// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32 operation encodings shared by the arbiter and its requesters
package rv;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    ADDI = 4'd2,
    XORI = 4'd3
  } RV32_INSTRUCTION;
endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester-side request/response channels of alu_arbiter
interface alu_arbiter_if #(
  parameter int NREQ = 2
) ();
  localparam int OPW = $bits(rv::RV32_INSTRUCTION);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_op1;
  logic [NREQ*32-1:0]   req_op2;
  logic [NREQ*32-1:0]   req_imm;
  logic [NREQ*OPW-1:0]  req_opcode;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_result;

  modport master (
    output req_valid, req_op1, req_op2, req_imm, req_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_imm, req_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between NREQ requesters, one op in flight
// Fixed priority by default; ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_arbiter_if.slave        bus,
  output logic [31:0]         alu_op1,
  output logic [31:0]         alu_op2,
  output logic [31:0]         alu_imm,
  output rv::RV32_INSTRUCTION alu_opcode,
  input  logic [31:0]         alu_result,
  output logic                busy
);
  localparam int IDXW = $clog2(NREQ);
  localparam int OPW  = $bits(rv::RV32_INSTRUCTION);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [31:0]         op1;
    logic [31:0]         op2;
    logic [31:0]         imm;
    rv::RV32_INSTRUCTION opcode;
  } op_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] gnt_q;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] cand;
  logic            win_found;
  logic            accept;
  op_t             op_q;
  logic [31:0]     res_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] last_gnt;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last_gnt) + k) % NREQ);
      if (!win_found && bus.req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= IDXW'(NREQ - 1);
    end else if (accept) begin
      last_gnt <= win;
    end
  end
`else
  // Scanning downward leaves the lowest valid index as the winner.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDXW'(i);
      if (bus.req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          accept        = 1'b1;
          bus.req_ready = NREQ'(1) << win;
          state_d       = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      op_q  <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        gnt_q       <= win;
        op_q.op1    <= 32'(bus.req_op1 >> (32 * win));
        op_q.op2    <= 32'(bus.req_op2 >> (32 * win));
        op_q.imm    <= 32'(bus.req_imm >> (32 * win));
        op_q.opcode <= rv::RV32_INSTRUCTION'(OPW'(bus.req_opcode >> (OPW * win)));
      end
      if (state_q == EXEC) begin
        res_q <= alu_result;
      end
    end
  end

  assign alu_op1        = op_q.op1;
  assign alu_op2        = op_q.op2;
  assign alu_imm        = op_q.imm;
  assign alu_opcode     = op_q.opcode;
  assign bus.rsp_valid  = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign bus.rsp_result = res_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  logic                clk = 1'b0;
  logic                rst_n;
  logic [31:0]         alu_op1, alu_op2, alu_imm, alu_result;
  rv::RV32_INSTRUCTION alu_opcode;
  logic                busy;

  alu_arbiter_if #(.NREQ(2)) bus ();

  alu_arbiter #(.NREQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_imm    (alu_imm),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_opcode)
      rv::ADD:  alu_result = alu_op1 + alu_op2;
      rv::SUB:  alu_result = alu_op1 - alu_op2;
      rv::ADDI: alu_result = alu_op1 + alu_imm;
      rv::XORI: alu_result = alu_op1 ^ alu_imm;
      default:  alu_result = 32'hDEAD_BEEF;
    endcase
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          grants_seen = 0;
  int          last_gnt_cyc = -1;
  bit          spacing_on = 1'b0;
  int          exp_gnt[$];
  int          exp_idx[$];
  logic [31:0] exp_res[$];

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Grant monitor: every accepted request must match the next expected winner.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          grants_seen++;
          if (exp_gnt.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_unexpected: got %0d expected none", i);
          end else begin
            check("grant_idx", 32'(i), 32'(exp_gnt.pop_front()));
          end
          if (spacing_on && last_gnt_cyc >= 0)
            check("grant_spacing", 32'(cyc - last_gnt_cyc), 32'd3);
          last_gnt_cyc = cyc;
        end
      end
    end
  end

  // Response monitor: every completed response is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (exp_res.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_unexpected: got port %0d result %h expected none", i, bus.rsp_result);
          end else begin
            check("rsp_port", 32'(i), 32'(exp_idx.pop_front()));
            check("rsp_result", bus.rsp_result, exp_res.pop_front());
          end
        end
      end
    end
  end

  task automatic set_ops(input int i, input rv::RV32_INSTRUCTION opc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    if (i == 0) begin
      bus.req_op1[31:0]   = a;
      bus.req_op2[31:0]   = b;
      bus.req_imm[31:0]   = im;
      bus.req_opcode[3:0] = opc;
    end else begin
      bus.req_op1[63:32]  = a;
      bus.req_op2[63:32]  = b;
      bus.req_imm[63:32]  = im;
      bus.req_opcode[7:4] = opc;
    end
  endtask

  task automatic issue(input int i, input rv::RV32_INSTRUCTION opc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] exp);
    set_ops(i, opc, a, b, im);
    bus.req_valid[i] = 1'b1;
    exp_gnt.push_back(i);
    exp_idx.push_back(i);
    exp_res.push_back(exp);
  endtask

  task automatic wait_accept(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.req_valid[i] && bus.req_ready[i]) && n < 20);
    check("accept_in_time", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 bus.req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_res.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_res.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_op1    = '0;
    bus.req_op2    = '0;
    bus.req_imm    = '0;
    bus.req_opcode = '0;
    bus.rsp_ready  = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_alu_op1", alu_op1, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle
    repeat (10) begin
      @(negedge clk);
      check("idle_req_ready", 32'(bus.req_ready), 32'd0);
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Single op: 5 + 7
    @(posedge clk);
    #1 bus.rsp_ready = 2'b11;
    issue(0, rv::ADDI, 32'd5, 32'd0, 32'd7, 32'd12);
    @(negedge clk);
    check("single_req_ready", 32'(bus.req_ready), 32'b01);
    check("single_busy_T", 32'(busy), 32'd0);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("single_busy_exec", 32'(busy), 32'd1);
    check("single_rsp_valid_exec", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("single_busy_resp", 32'(busy), 32'd1);
    check("single_rsp_valid_resp", 32'(bus.rsp_valid), 32'b01);
    @(negedge clk);
    check("single_busy_after", 32'(busy), 32'd0);
    drain();

    // Backpressure: 0xFFFFFFFF + 1 wraps to 0
    @(posedge clk);
    #1 bus.rsp_ready = 2'b00;
    issue(1, rv::ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    wait_accept(1);
    @(negedge clk);
    check("bp_busy_exec", 32'(busy), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'b10);
      check("bp_rsp_result_held", bus.rsp_result, 32'd0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    drain();

    // Contention with both requesters valid continuously
    @(posedge clk);
    #1 bus.rsp_ready = 2'b11;
    set_ops(0, rv::ADDI, 32'd10, 32'd0, 32'd1);
    set_ops(1, rv::ADD, 32'd20, 32'd22, 32'd0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_gnt = '{0, 1, 0, 1};
    exp_idx = '{0, 1, 0, 1};
    exp_res = '{32'd11, 32'd42, 32'd11, 32'd42};
`else
    exp_gnt = '{0, 0, 0, 0};
    exp_idx = '{0, 0, 0, 0};
    exp_res = '{32'd11, 32'd11, 32'd11, 32'd11};
`endif
    spacing_on    = 1'b1;
    last_gnt_cyc  = -1;
    base          = grants_seen;
    bus.req_valid = 2'b11;
    n = 0;
    while (grants_seen < base + 4 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1 bus.req_valid = 2'b00;
    check("contention_grants", 32'(grants_seen - base), 32'd4);
    drain();
    spacing_on = 1'b0;

    // Wrong-port ready: requester 1 ready is ignored while requester 0 owns the result
    @(posedge clk);
    #1 bus.rsp_ready = 2'b10;
    issue(0, rv::SUB, 32'd100, 32'd58, 32'd0, 32'd42);
    wait_accept(0);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check("wrongport_rsp_valid", 32'(bus.rsp_valid), 32'b01);
      check("wrongport_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 2'b01;
    drain();

    // Mid-op reset during EXEC discards the operation
    @(posedge clk);
    #1 bus.rsp_ready = 2'b11;
    issue(1, rv::ADD, 32'd7, 32'd8, 32'd0, 32'd15);
    wait_accept(1);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_alu_op1", alu_op1, 32'd0);
    check("midrst_rsp_result", bus.rsp_result, 32'd0);
    exp_idx.delete();
    exp_res.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 issue(1, rv::ADDI, 32'd0, 32'd0, 32'd3, 32'd3);
    wait_accept(1);
    drain();

    repeat (3) @(negedge clk);
    check("grant_queue_empty", 32'(exp_gnt.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
